// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants, FSM encoding and timing helpers for uart_rx_param
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync_filter
// Purpose  : 2-FF synchroniser, 3-sample history, majority bit and falling edge
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync_filter (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic bit_o,
    output logic fall_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [2:0] hist_q;

    // Reset to the idle-high level so release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[1:0], sync2_q};
        end
    end

    assign bit_o  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    assign fall_o = hist_q[0] & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised UART receiver (5-9 data bits, N/O/E parity, 1-2 stop)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int                CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int                HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int                CNT_W        = calc_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF     = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]        BIT_LAST     = 4'(DATA_BITS - 1);
    localparam logic              STOP_LAST    = (STOP_BITS == 2);

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   fe_q, fe_d;
    logic                   pe_q, pe_d;
    logic                   ovr_q, ovr_d;
    logic                   deliver;
    logic                   line_bit;
    logic                   line_fall;
    logic                   tick;
    logic                   par_exp;

    uart_rx_sync_filter u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rs232_rx),
        .bit_o  (line_bit),
        .fall_o (line_fall)
    );

    assign tick    = (cnt_q == CNT_LAST);
    assign par_exp = (PARITY == PARITY_ODD) ? ~^shift_q : ^shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? '0 : cnt_q + CNT_ONE;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        deliver    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (line_fall) begin
                    state_d    = ST_START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = line_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {line_bit, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    perr_d  = (line_bit != par_exp);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    ferr_d = ferr_q | ~line_bit;
                    if (stop_idx_q == STOP_LAST) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A word arriving in the accept cycle wins over the clear of rx_valid
    always_comb begin
        valid_d = valid_q;
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            valid_d = 1'b1;
        end
        ovr_d  = deliver & valid_q & ~rx_ready;
        data_d = deliver ? shift_q : data_q;
        fe_d   = deliver ? ferr_d  : fe_q;
        pe_d   = deliver ? perr_q  : pe_q;
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ovr_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Purpose  : Directed self-checking bench for 8N1, 7E1 and 8N2 receivers
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    logic       clk;
    logic       rst_n;
    logic [2:0] rx;
    logic [2:0] rdy;
    wire  [2:0] vld, fe, pe, ovr, busy;
    wire  [7:0] d0;
    wire  [6:0] d1;
    wire  [7:0] d2;

    int         checks   = 0;
    int         failures = 0;

    int         acc[3]      = '{0, 0, 0};
    int         vcyc[3]     = '{0, 0, 0};
    int         ovc[3]      = '{0, 0, 0};
    int         busy_cnt[3] = '{0, 0, 0};
    logic [8:0] last_d[3];
    logic       last_fe[3];
    logic       last_pe[3];

    uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rs232_rx(rx[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]), .rx_busy(busy[0]));

    uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst_n(rst_n), .rs232_rx(rx[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1]), .rx_busy(busy[1]));

    uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .rs232_rx(rx[2]), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ovr[2]), .rx_busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vld[k])  vcyc[k]     = vcyc[k] + 1;
            if (busy[k]) busy_cnt[k] = busy_cnt[k] + 1;
            if (ovr[k])  ovc[k]      = ovc[k] + 1;
            if (vld[k] && rdy[k]) begin
                acc[k]     = acc[k] + 1;
                last_fe[k] = fe[k];
                last_pe[k] = pe[k];
                last_d[k]  = (k == 0) ? {1'b0, d0} : (k == 1) ? {2'b00, d1} : {1'b0, d2};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // bits[0] goes out first; gmask marks bits that get a 1-clock inverted glitch mid-bit
    task automatic send_frame(input int k, input logic [15:0] bits, input int n, input logic [15:0] gmask);
        for (int i = 0; i < n; i++) begin
            rx[k] = bits[i];
            if (gmask[i]) begin
                repeat (4) tick();
                rx[k] = ~bits[i];
                tick();
                rx[k] = bits[i];
                repeat (5) tick();
            end else begin
                repeat (10) tick();
            end
        end
        rx[k] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 3'b111;
        rdy   = 3'b111;
        repeat (3) tick();
        if ({vld, busy, fe, pe, ovr} !== 15'd0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0", {vld, busy, fe, pe, ovr});
        end
        checks++;
        if ({d0, d1, d2} !== 23'd0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {d0, d1, d2});
        end
        checks++;
        rst_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_8n1();
        int a, v, b;
        a = acc[0]; v = vcyc[0]; b = busy_cnt[0];
        send_frame(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10, 16'h0);
        repeat (3) tick();
        if (acc[0] - a !== 1)          begin failures++; $display("FAIL 8n1_accepts got=%0d exp=1", acc[0] - a); end
        checks++;
        if (last_d[0] !== 9'h0A5)      begin failures++; $display("FAIL 8n1_data got=%h exp=a5", last_d[0]); end
        checks++;
        if ({last_fe[0], last_pe[0]} !== 2'b00) begin failures++; $display("FAIL 8n1_errs got=%b exp=00", {last_fe[0], last_pe[0]}); end
        checks++;
        if (vcyc[0] - v !== 1)         begin failures++; $display("FAIL 8n1_valid_cycles got=%0d exp=1", vcyc[0] - v); end
        checks++;
        if (busy_cnt[0] - b !== 95)    begin failures++; $display("FAIL 8n1_busy_cycles got=%0d exp=95", busy_cnt[0] - b); end
        checks++;
        if (busy[0] !== 1'b0)          begin failures++; $display("FAIL 8n1_busy_end got=%b exp=0", busy[0]); end
        checks++;
    endtask

    task automatic test_7e1();
        int a;
        a = acc[1];
        send_frame(1, {6'h3F, 1'b1, 1'b0, 7'h35, 1'b0}, 10, 16'h0);
        repeat (3) tick();
        if (acc[1] - a !== 1)          begin failures++; $display("FAIL 7e1_good_accepts got=%0d exp=1", acc[1] - a); end
        checks++;
        if ({last_d[1], last_fe[1], last_pe[1]} !== {9'h035, 2'b00}) begin
            failures++; $display("FAIL 7e1_good got=%h fe=%b pe=%b exp=35 fe=0 pe=0", last_d[1], last_fe[1], last_pe[1]);
        end
        checks++;
        send_frame(1, {6'h3F, 1'b1, 1'b1, 7'h35, 1'b0}, 10, 16'h0);
        repeat (3) tick();
        if (acc[1] - a !== 2)          begin failures++; $display("FAIL 7e1_bad_accepts got=%0d exp=2", acc[1] - a); end
        checks++;
        if ({last_d[1], last_fe[1], last_pe[1]} !== {9'h035, 2'b01}) begin
            failures++; $display("FAIL 7e1_bad got=%h fe=%b pe=%b exp=35 fe=0 pe=1", last_d[1], last_fe[1], last_pe[1]);
        end
        checks++;
    endtask

    task automatic test_8n2();
        int a;
        a = acc[2];
        send_frame(2, {5'h1F, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, 16'h0);
        repeat (3) tick();
        if (acc[2] - a !== 1)          begin failures++; $display("FAIL 8n2_ferr_accepts got=%0d exp=1", acc[2] - a); end
        checks++;
        if ({last_d[2], last_fe[2]} !== {9'h03C, 1'b1}) begin
            failures++; $display("FAIL 8n2_ferr got=%h fe=%b exp=3c fe=1", last_d[2], last_fe[2]);
        end
        checks++;
        repeat (20) tick();
        send_frame(2, {5'h1F, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 16'h0);
        repeat (3) tick();
        if (acc[2] - a !== 2)          begin failures++; $display("FAIL 8n2_clean_accepts got=%0d exp=2", acc[2] - a); end
        checks++;
        if ({last_d[2], last_fe[2]} !== {9'h001, 1'b0}) begin
            failures++; $display("FAIL 8n2_clean got=%h fe=%b exp=01 fe=0", last_d[2], last_fe[2]);
        end
        checks++;
    endtask

    task automatic test_glitch();
        int a, v, b;
        a = acc[0]; v = vcyc[0]; b = busy_cnt[0];
        rx[0] = 1'b0;
        repeat (3) tick();
        rx[0] = 1'b1;
        repeat (30) tick();
        if (vcyc[0] - v !== 0)         begin failures++; $display("FAIL false_start_valid got=%0d exp=0", vcyc[0] - v); end
        checks++;
        if (busy_cnt[0] - b !== 5)     begin failures++; $display("FAIL false_start_busy got=%0d exp=5", busy_cnt[0] - b); end
        checks++;
        if (busy[0] !== 1'b0)          begin failures++; $display("FAIL false_start_idle got=%b exp=0", busy[0]); end
        checks++;
        send_frame(0, {6'h3F, 1'b1, 8'h96, 1'b0}, 10, 16'h0006);
        repeat (3) tick();
        if (acc[0] - a !== 1)          begin failures++; $display("FAIL glitch_accepts got=%0d exp=1", acc[0] - a); end
        checks++;
        if (last_d[0] !== 9'h096)      begin failures++; $display("FAIL glitch_data got=%h exp=96", last_d[0]); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int a, o;
        a = acc[0]; o = ovc[0];
        rdy[0] = 1'b0;
        send_frame(0, {6'h3F, 1'b1, 8'h11, 1'b0}, 10, 16'h0);
        send_frame(0, {6'h3F, 1'b1, 8'h22, 1'b0}, 10, 16'h0);
        repeat (3) tick();
        if (ovc[0] - o !== 1)          begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", ovc[0] - o); end
        checks++;
        if ({vld[0], d0} !== {1'b1, 8'h22}) begin
            failures++; $display("FAIL overrun_word got=%b/%h exp=1/22", vld[0], d0);
        end
        checks++;
        rdy[0] = 1'b1;
        tick();
        tick();
        if (acc[0] - a !== 1)          begin failures++; $display("FAIL overrun_accepts got=%0d exp=1", acc[0] - a); end
        checks++;
        if (last_d[0] !== 9'h022)      begin failures++; $display("FAIL overrun_accept_data got=%h exp=22", last_d[0]); end
        checks++;
        if (vld[0] !== 1'b0)           begin failures++; $display("FAIL overrun_valid_drop got=%b exp=0", vld[0]); end
        checks++;
    endtask

    task automatic test_reset_midframe();
        int a;
        a = acc[0];
        rx[0] = 1'b0;
        repeat (10) tick();
        rx[0] = 1'b1;
        repeat (40) tick();
        if (busy[0] !== 1'b1)          begin failures++; $display("FAIL midframe_busy got=%b exp=1", busy[0]); end
        checks++;
        rst_n = 1'b0;
        #1;
        if ({vld[0], busy[0], fe[0], pe[0], ovr[0], d0} !== 13'd0) begin
            failures++; $display("FAIL midframe_reset got=%b exp=0", {vld[0], busy[0], fe[0], pe[0], ovr[0], d0});
        end
        checks++;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        send_frame(0, {6'h3F, 1'b1, 8'h5A, 1'b0}, 10, 16'h0);
        repeat (3) tick();
        if (acc[0] - a !== 1)          begin failures++; $display("FAIL post_reset_accepts got=%0d exp=1", acc[0] - a); end
        checks++;
        if (last_d[0] !== 9'h05A)      begin failures++; $display("FAIL post_reset_data got=%h exp=5a", last_d[0]); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_8n2();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
